// File: rtl/subinst_rr_scheduler_if.sv
// Request/grant bundle between the sub-instance requesters (master) and the
// shared-resource round-robin scheduler (slave).
interface subinst_rr_scheduler_if #(
   parameter int N_REQ = 5,
   parameter int ID_W  = 3,
   parameter int CNT_W = 16
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] rel;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] grant_cnt;

   modport master (output req, rel, input gnt, gnt_id, busy, timeout, grant_cnt);
   modport slave  (input req, rel, output gnt, gnt_id, busy, timeout, grant_cnt);
endinterface

// File: rtl/subinst_rr_scheduler.sv
// Round-robin owner scheduler for one shared resource: one-hot registered grant,
// hold-time limit with forced revoke, one-cycle dead gap between owners.
module subinst_rr_scheduler #(
   parameter int N_REQ    = 5,
   parameter int ID_W     = 3,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   subinst_rr_scheduler_if.slave bus
);
   localparam int               HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RECOVER} state_t;

   state_t           r_state,     w_state_nxt;
   logic [N_REQ-1:0] r_gnt,       w_gnt_nxt;
   logic [ID_W-1:0]  r_gnt_id,    w_gnt_id_nxt;
   logic             r_busy,      w_busy_nxt;
   logic             r_timeout,   w_timeout_nxt;
   logic [CNT_W-1:0] r_grant_cnt, w_cnt_nxt;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
   logic [ID_W-1:0]  r_last_id,   w_last_nxt;

   logic             w_found;
   logic [ID_W-1:0]  w_sel;
   logic             w_own_end;
   logic             w_hold_max;

   // First set request strictly after 'last', wrapping modulo N_REQ; returns {found, index}.
   function automatic logic [ID_W:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  last);
      logic             found;
      logic [ID_W-1:0]  idx;
      logic [N_REQ-1:0] sh;
      int               k;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         k  = (int'(last) + i) % N_REQ;
         sh = req >> k;
         if (!found && sh[0]) begin
            found = 1'b1;
            idx   = ID_W'(k);
         end
      end
      return {found, idx};
   endfunction

   assign {w_found, w_sel} = f_rr_pick(bus.req, r_last_id);
   // Only the owner's own rel/req bits can end a grant.
   assign w_own_end  = |(r_gnt & (bus.rel | ~bus.req));
   assign w_hold_max = (r_hold_cnt == HOLD_W'(MAX_HOLD));

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      w_cnt_nxt     = r_grant_cnt;
      w_hold_nxt    = r_hold_cnt;
      w_last_nxt    = r_last_id;
      unique case (r_state)
         ST_GRANT: begin
            if (w_own_end || w_hold_max) begin
               w_state_nxt   = ST_RECOVER;
               w_gnt_nxt     = '0;
               w_busy_nxt    = 1'b0;
               w_last_nxt    = r_gnt_id;
               w_timeout_nxt = ~w_own_end;
            end else begin
               w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            // IDLE and RECOVER arbitrate the same way; RECOVER is the gnt=0 gap cycle.
            w_gnt_nxt  = '0;
            w_busy_nxt = 1'b0;
            if (w_found) begin
               w_state_nxt  = ST_GRANT;
               w_gnt_nxt    = ONE << w_sel;
               w_gnt_id_nxt = w_sel;
               w_busy_nxt   = 1'b1;
               w_hold_nxt   = HOLD_W'(1);
               if (r_grant_cnt != '1) w_cnt_nxt = r_grant_cnt + CNT_W'(1);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_busy      <= 1'b0;
         r_timeout   <= 1'b0;
         r_grant_cnt <= '0;
         r_hold_cnt  <= '0;
         r_last_id   <= ID_W'(N_REQ - 1);
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_id    <= w_gnt_id_nxt;
         r_busy      <= w_busy_nxt;
         r_timeout   <= w_timeout_nxt;
         r_grant_cnt <= w_cnt_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_last_id   <= w_last_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.busy      = r_busy;
   assign bus.timeout   = r_timeout;
   assign bus.grant_cnt = r_grant_cnt;
endmodule
